// File: rtl/stack_mem_ctrl.sv
// stack_mem_ctrl
//   Stack controller that sits directly in front of a 32x8 data memory. It turns push and pop
//   requests into single memory write or read cycles. It also keeps the stack pointer and the
//   full/empty state. The stack grows downward from BASE to BASE-DEPTH+1.
//   BASE+1 >= DEPTH must hold, so addresses never wrap.
//
// Ports
//   clk, rst              clock (rising edge), synchronous active-high reset
//   push, pop, din        requests, sampled only while ready=1; push wins over pop
//   ready                 high in IDLE only
//   dout, dout_valid      last popped byte (held), one-cycle pulse when it is updated
//   full, empty, err      stack status; err pulses on push-when-full / pop-when-empty
//   mem_adr, mem_data     memory address / write data
//   mem_wen, mem_read     memory write enable (gated by rst) / read enable
//   mem_rdata             combinational memory read data
module stack_mem_ctrl #(
    parameter int unsigned ADR_W  = 5,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned BASE   = 23,
    parameter int unsigned DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic              ready,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              full,
    output logic              empty,
    output logic              err,
    output logic [ADR_W-1:0]  mem_adr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wen,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam logic [ADR_W-1:0] BaseAdr  = ADR_W'(BASE);
    localparam logic [CntW-1:0]  DepthCnt = CntW'(DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StWrite,
        StRead
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0] wlatch_q, wlatch_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              dout_valid_q, dout_valid_d;
    logic              err_q, err_d;
    logic              wen_raw;
    logic [ADR_W-1:0]  cnt_adr;

    assign cnt_adr    = ADR_W'(cnt_q);
    assign full       = (cnt_q == DepthCnt);
    assign empty      = (cnt_q == '0);
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign err        = err_q;
    // A reset landing on the write cycle must leave memory untouched.
    assign mem_wen    = wen_raw & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            wlatch_q     <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wlatch_q     <= wlatch_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        wlatch_d     = wlatch_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        err_d        = 1'b0;
        ready        = 1'b0;
        mem_adr      = '0;
        mem_data     = '0;
        wen_raw      = 1'b0;
        mem_read     = 1'b0;

        unique case (state_q)
            StIdle: begin
                ready = 1'b1;
                // Push has priority; a simultaneous pop is dropped without an error.
                if (push) begin
                    if (full) begin
                        err_d = 1'b1;
                    end else begin
                        wlatch_d = din;
                        state_d  = StWrite;
                    end
                end else if (pop) begin
                    if (empty) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = StRead;
                    end
                end
            end
            StWrite: begin
                // Next free slot sits cnt entries below the bottom slot.
                mem_adr  = BaseAdr - cnt_adr;
                mem_data = wlatch_q;
                wen_raw  = 1'b1;
                cnt_d    = cnt_q + CntW'(1);
                state_d  = StIdle;
            end
            StRead: begin
                // Top of stack is the last written slot: BASE-(cnt-1).
                mem_adr      = BaseAdr - cnt_adr + ADR_W'(1);
                mem_read     = 1'b1;
                dout_d       = mem_rdata;
                dout_valid_d = 1'b1;
                cnt_d        = cnt_q - CntW'(1);
                state_d      = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

endmodule

// File: tb/tb_stack_mem_ctrl.sv
module tb_stack_mem_ctrl;

    localparam int ADR_W  = 5;
    localparam int DATA_W = 8;
    localparam int BASE   = 23;
    localparam int DEPTH  = 8;

    logic              clk;
    logic              rst;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] din;
    logic              ready;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              full;
    logic              empty;
    logic              err;
    logic [ADR_W-1:0]  mem_adr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_wen;
    logic              mem_read;
    logic [DATA_W-1:0] mem_rdata;

    int checks   = 0;
    int failures = 0;

    stack_mem_ctrl #(
        .ADR_W (ADR_W),
        .DATA_W(DATA_W),
        .BASE  (BASE),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .din       (din),
        .ready     (ready),
        .dout      (dout),
        .dout_valid(dout_valid),
        .full      (full),
        .empty     (empty),
        .err       (err),
        .mem_adr   (mem_adr),
        .mem_data  (mem_data),
        .mem_wen   (mem_wen),
        .mem_read  (mem_read),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory the controller drives.
    logic [DATA_W-1:0] mem [32];
    initial for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    always @(posedge clk) if (mem_wen) mem[mem_adr] <= mem_data;
    assign mem_rdata = mem[mem_adr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a queue as the stack plus the one pending memory operation.
    byte unsigned m_stk[$];
    int           m_op;      // 0 none, 1 push in flight, 2 pop in flight
    byte unsigned m_wdata;
    byte unsigned m_dout;
    bit           m_dv;
    bit           m_err;
    bit           cmp_en = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_stk.delete();
            m_op = 0; m_dout = 0; m_dv = 0; m_err = 0;
        end else begin
            m_dv  = 0;
            m_err = 0;
            if (m_op == 1) begin
                m_stk.push_back(m_wdata);
                m_op = 0;
            end else if (m_op == 2) begin
                m_dout = m_stk.pop_back();
                m_dv   = 1;
                m_op   = 0;
            end else if (push) begin
                if (m_stk.size() == DEPTH) m_err = 1;
                else begin m_op = 1; m_wdata = din; end
            end else if (pop) begin
                if (m_stk.size() == 0) m_err = 1;
                else m_op = 2;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            int sz;
            int e_adr;
            sz    = m_stk.size();
            e_adr = (m_op == 1) ? BASE - sz : (m_op == 2) ? BASE - sz + 1 : 0;
            chk("m_ready", 32'(ready), 32'(m_op == 0));
            chk("m_full", 32'(full), 32'(sz == DEPTH));
            chk("m_empty", 32'(empty), 32'(sz == 0));
            chk("m_err", 32'(err), 32'(m_err));
            chk("m_dout_valid", 32'(dout_valid), 32'(m_dv));
            chk("m_dout", 32'(dout), 32'(m_dout));
            chk("m_mem_wen", 32'(mem_wen), 32'(m_op == 1 && !rst));
            chk("m_mem_read", 32'(mem_read), 32'(m_op == 2));
            chk("m_mem_adr", 32'(mem_adr), 32'(e_adr));
            chk("m_mem_data", 32'(mem_data), 32'((m_op == 1) ? m_wdata : 8'h00));
        end
    end

    // Inputs change just after the falling edge, away from both sampling points.
    task automatic drive(input logic p, input logic q, input logic [7:0] d);
        @(negedge clk);
        #1;
        push = p;
        pop  = q;
        din  = d;
    endtask

    task automatic do_push(input logic [7:0] d, input int exp_adr);
        drive(1'b1, 1'b0, d);
        drive(1'b0, 1'b0, 8'h00);
        chk("push_wen", 32'(mem_wen), 32'd1);
        chk("push_adr", 32'(mem_adr), 32'(exp_adr));
        chk("push_data", 32'(mem_data), 32'(d));
    endtask

    task automatic do_pop(input logic [7:0] exp_d, input int exp_adr);
        drive(1'b0, 1'b1, 8'h00);
        drive(1'b0, 1'b0, 8'h00);
        chk("pop_read", 32'(mem_read), 32'd1);
        chk("pop_adr", 32'(mem_adr), 32'(exp_adr));
        @(negedge clk);
        chk("pop_dout", 32'(dout), 32'(exp_d));
        chk("pop_valid", 32'(dout_valid), 32'd1);
        chk("pop_ready", 32'(ready), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst  = 1'b1;
        push = 1'b0;
        pop  = 1'b0;
        din  = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 rst = 1'b0;
        cmp_en = 1'b1;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_wen", 32'(mem_wen), 32'd0);
        chk("rst_read", 32'(mem_read), 32'd0);

        // Single push/pop round trip.
        do_push(8'hA5, 23);
        do_pop(8'hA5, 23);
        chk("rt_empty", 32'(empty), 32'd1);
        @(negedge clk);
        chk("rt_valid_pulse", 32'(dout_valid), 32'd0);

        // Fill to full, overflow, drain.
        for (int i = 1; i <= 8; i++) do_push(8'(i), 24 - i);
        @(negedge clk);
        chk("fill_full", 32'(full), 32'd1);
        drive(1'b1, 1'b0, 8'h09);
        drive(1'b0, 1'b0, 8'h00);
        chk("ovf_err", 32'(err), 32'd1);
        chk("ovf_wen", 32'(mem_wen), 32'd0);
        chk("ovf_full", 32'(full), 32'd1);
        @(negedge clk);
        chk("ovf_err_pulse", 32'(err), 32'd0);
        for (int i = 8; i >= 1; i--) do_pop(8'(i), 24 - i);
        chk("drain_empty", 32'(empty), 32'd1);

        // Underflow.
        drive(1'b0, 1'b1, 8'h00);
        drive(1'b0, 1'b0, 8'h00);
        chk("unf_err", 32'(err), 32'd1);
        chk("unf_valid", 32'(dout_valid), 32'd0);
        chk("unf_read", 32'(mem_read), 32'd0);
        @(negedge clk);
        chk("unf_err_pulse", 32'(err), 32'd0);
        chk("unf_dout_held", 32'(dout), 32'h01);

        // Simultaneous push and pop: push wins.
        do_push(8'h3C, 23);
        drive(1'b1, 1'b1, 8'h77);
        drive(1'b0, 1'b0, 8'h00);
        chk("both_wen", 32'(mem_wen), 32'd1);
        chk("both_adr", 32'(mem_adr), 32'd22);
        chk("both_data", 32'(mem_data), 32'h77);
        chk("both_read", 32'(mem_read), 32'd0);
        @(negedge clk);
        chk("both_err", 32'(err), 32'd0);
        chk("both_valid", 32'(dout_valid), 32'd0);
        do_pop(8'h77, 22);
        do_pop(8'h3C, 23);

        // Reset during the write cycle aborts the write.
        drive(1'b1, 1'b0, 8'hEE);
        @(negedge clk);
        #1;
        push = 1'b0;
        rst  = 1'b1;
        #1 chk("abort_wen", 32'(mem_wen), 32'd0);
        @(negedge clk);
        #1 rst = 1'b0;
        chk("abort_mem23", 32'(mem[23]), 32'h3C);
        chk("abort_empty", 32'(empty), 32'd1);
        chk("abort_ready", 32'(ready), 32'd1);
        chk("abort_dout", 32'(dout), 32'd0);
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
